// File: rtl/sram_arbiter.sv
// Round-robin arbiter and access sequencer sharing one asynchronous SRAM among CHANNELS clients.
// Define SRAM_ARB_PRIORITY0_EN to give channel 0 absolute priority over the others.
`timescale 1ns/1ps
module sram_arbiter #(
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CHANNELS-1:0]        ch_req,
    input  logic [CHANNELS-1:0]        ch_we,
    input  logic [CHANNELS*ADDR_W-1:0] ch_addr,
    input  logic [CHANNELS*DATA_W-1:0] ch_wdata,
    output logic [CHANNELS-1:0]        ch_ack,
    output logic [DATA_W-1:0]          rdata,
    output logic                       busy,
    output logic [ADDR_W-1:0]          address_pins,
    output logic [DATA_W-1:0]          data_pins_out,
    output logic                       data_pins_out_en,
    input  logic [DATA_W-1:0]          data_pins_in,
    output logic                       OE,
    output logic                       WE,
    output logic                       CS
);
    localparam int unsigned GW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [GW-1:0]       last_grant_q, last_grant_d;
    logic                write_q, write_d;
    logic [CHANNELS-1:0] ack_d;
    logic [DATA_W-1:0]   rdata_d, dout_d;
    logic [ADDR_W-1:0]   addr_d;
    logic                oe_d, we_d, cs_d, out_en_d, busy_d;

    logic [CHANNELS-1:0] rr_req_c;
    logic [GW-1:0]       win_c;
    logic                any_req_c;

`ifdef SRAM_ARB_PRIORITY0_EN
    assign rr_req_c = {ch_req[CHANNELS-1:1], 1'b0};
`else
    assign rr_req_c = ch_req;
`endif
    assign any_req_c = |ch_req;

    // Winner: first requester after last_grant, wrapping; channel 0 overrides in priority mode
    always_comb begin
        logic [GW-1:0] idx;
        logic          found;
        win_c = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 1; i <= CHANNELS; i++) begin
            idx = GW'((32'(last_grant_q) + i) % CHANNELS);
            if (!found && rr_req_c[idx]) begin
                win_c = idx;
                found = 1'b1;
            end
        end
`ifdef SRAM_ARB_PRIORITY0_EN
        if (ch_req[0]) win_c = '0;
`endif
    end

    // Next state and next registered pin values
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        write_d      = write_q;
        ack_d        = '0;
        rdata_d      = rdata;
        addr_d       = address_pins;
        dout_d       = data_pins_out;
        oe_d         = 1'b1;
        we_d         = 1'b1;
        cs_d         = 1'b1;
        out_en_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req_c) begin
                    state_d      = ACCESS;
                    last_grant_d = win_c;
                    cnt_d        = CW'(WAIT_CYCLES);
                    write_d      = ch_we[win_c];
                    addr_d       = ch_addr[32'(win_c)*ADDR_W +: ADDR_W];
                    if (ch_we[win_c]) dout_d = ch_wdata[32'(win_c)*DATA_W +: DATA_W];
                    cs_d         = 1'b0;
                    oe_d         = ch_we[win_c];
                    we_d         = !ch_we[win_c];
                    out_en_d     = ch_we[win_c];
                end
            end
            ACCESS: begin
                cs_d     = 1'b0;
                out_en_d = write_q;
                if (cnt_q == '0) begin
                    state_d             = RECOVER;
                    ack_d[last_grant_q] = 1'b1;
                    if (!write_q) rdata_d = data_pins_in;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    oe_d  = write_q;
                    we_d  = !write_q;
                end
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            last_grant_q     <= GW'(CHANNELS - 1);
            write_q          <= 1'b0;
            ch_ack           <= '0;
            rdata            <= '0;
            busy             <= 1'b0;
            address_pins     <= '0;
            data_pins_out    <= '0;
            data_pins_out_en <= 1'b0;
            OE               <= 1'b1;
            WE               <= 1'b1;
            CS               <= 1'b1;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            last_grant_q     <= last_grant_d;
            write_q          <= write_d;
            ch_ack           <= ack_d;
            rdata            <= rdata_d;
            busy             <= busy_d;
            address_pins     <= addr_d;
            data_pins_out    <= dout_d;
            data_pins_out_en <= out_en_d;
            OE               <= oe_d;
            WE               <= we_d;
            CS               <= cs_d;
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: 4 channels, WAIT_CYCLES=1, behavioural SRAM and arbiter model.
`timescale 1ns/1ps
module tb_sram_arbiter;
    localparam int unsigned AW  = 18;
    localparam int unsigned DW  = 16;
    localparam int unsigned NCH = 4;
    localparam int unsigned WC  = 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH-1:0]    ch_req, ch_we, ch_ack;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH*DW-1:0] ch_wdata;
    logic [DW-1:0]     rdata, data_pins_out, data_pins_in;
    logic [AW-1:0]     address_pins;
    logic              busy, data_pins_out_en, OE, WE, CS;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CHANNELS(NCH), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .reset(reset), .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr),
        .ch_wdata(ch_wdata), .ch_ack(ch_ack), .rdata(rdata), .busy(busy),
        .address_pins(address_pins), .data_pins_out(data_pins_out),
        .data_pins_out_en(data_pins_out_en), .data_pins_in(data_pins_in),
        .OE(OE), .WE(WE), .CS(CS)
    );

    // Asynchronous SRAM: combinational read while selected, write sampled on clock while WE low
    logic [DW-1:0] sram   [0:1023];
    logic [DW-1:0] shadow [0:1023];
    logic          poke_en = 1'b0;
    logic [9:0]    poke_a  = '0;
    logic [DW-1:0] poke_d  = '0;
    assign data_pins_in = (!CS && !OE) ? sram[address_pins[9:0]] : 16'hDEAD;
    always @(posedge clk) begin
        if (poke_en) sram[poke_a] <= poke_d;
        else if (!CS && !WE && data_pins_out_en) sram[address_pins[9:0]] <= data_pins_out;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic poke(input logic [9:0] a, input logic [DW-1:0] d);
        poke_en = 1'b1; poke_a = a; poke_d = d; shadow[a] = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic set_ch(input int c, input logic req, input logic we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        ch_req[c] = req; ch_we[c] = we;
        ch_addr[c*AW +: AW] = a; ch_wdata[c*DW +: DW] = d;
    endtask

    function automatic int oh2i(input logic [NCH-1:0] v);
        for (int i = 0; i < NCH; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Single access from an idle arbiter; returns ack vector, rdata and latency in cycles
    task automatic do_access(input int c, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             output logic [NCH-1:0] ack_v, output logic [DW-1:0] rd, output int lat);
        ack_v = '0; rd = '0; lat = -1;
        set_ch(c, 1'b1, we, a, d);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ch_ack != '0) begin
                ack_v = ch_ack; rd = rdata; lat = i;
                break;
            end
        end
        ch_req[c] = 1'b0;
        if (we) shadow[a[9:0]] = d;
        @(negedge clk);
    endtask

    // Fixed 8-cycle observation window of one access, counting strobe activity
    task automatic observe(input int c, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output int oe_n, output int we_n, output int wd_n, output int addr_bad,
                           output int ack_at, output int acks, output logic [NCH-1:0] ack_v,
                           output logic [DW-1:0] rd);
        oe_n = 0; we_n = 0; wd_n = 0; addr_bad = 0; ack_at = -1; acks = 0; ack_v = '0; rd = '0;
        set_ch(c, 1'b1, we, a, d);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (!OE) oe_n++;
            if (!WE) we_n++;
            if (!WE && data_pins_out_en && data_pins_out == d) wd_n++;
            if (!CS && address_pins != a) addr_bad++;
            if (ch_ack != '0) begin
                acks++;
                if (ack_at < 0) begin ack_at = i; ack_v = ch_ack; rd = rdata; end
                ch_req[c] = 1'b0;
            end
        end
        if (we) shadow[a[9:0]] = d;
    endtask

    task automatic pulse_reset();
        reset = 1'b0; ch_req = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    int ord [0:7];
    int tim [0:7];
    int n_got;

    task automatic collect(input int target);
        for (int t = 0; t < 60 && n_got < target; t++) begin
            @(negedge clk);
            if (ch_ack != '0) begin
                chk("ack_onehot", 32'($onehot(ch_ack)), 32'd1);
                ord[n_got] = oh2i(ch_ack);
                tim[n_got] = int'($time);
                n_got++;
            end
        end
    endtask

    typedef struct {
        int            ch;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    initial begin
        vec_t          vecs [0:7];
        logic [NCH-1:0] ack_v;
        logic [DW-1:0]  rd;
        int lat, oe_n, we_n, wd_n, addr_bad, ack_at, acks, acks_total, t0;
        int exp_ord [0:7];
        int n_exp;

        vecs[0] = '{2, 1'b1, 18'd3,  16'hA5A5, 16'h0000};
        vecs[1] = '{3, 1'b0, 18'd3,  16'h0000, 16'hA5A5};
        vecs[2] = '{1, 1'b0, 18'd7,  16'h0000, 16'h1007};
        vecs[3] = '{0, 1'b1, 18'd7,  16'h0F0F, 16'h0000};
        vecs[4] = '{2, 1'b0, 18'd7,  16'h0000, 16'h0F0F};
        vecs[5] = '{3, 1'b1, 18'd0,  16'hFFFF, 16'h0000};
        vecs[6] = '{1, 1'b0, 18'd0,  16'h0000, 16'hFFFF};
        vecs[7] = '{0, 1'b0, 18'd15, 16'h0000, 16'h100F};

        reset = 1'b0; ch_req = '0; ch_we = '0; ch_addr = '0; ch_wdata = '0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) poke(10'(i), 16'h1000 + 16'(i));
        poke(10'h123, 16'hBEEF);

        // Reset held with every channel requesting
        for (int c = 0; c < NCH; c++) set_ch(c, 1'b1, 1'b0, AW'(c), '0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_strobes", {29'd0, CS, OE, WE}, 32'h7);
            chk("rst_out_en", 32'(data_pins_out_en), 32'd0);
            chk("rst_ack", 32'(ch_ack), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
        end
        chk("rst_pins", {address_pins, 14'd0} | 32'(data_pins_out) | 32'(rdata), 32'd0);
        reset = 1'b1;
        lat = -1; ack_v = '0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (ch_ack != '0) begin lat = i; ack_v = ch_ack; break; end
        end
        chk("first_grant_ch", 32'(ack_v), 32'h1);
        chk("first_grant_lat", 32'(lat), 32'(WC + 2));
        ch_req = '0;
        repeat (2) @(negedge clk);

        // Table-driven single accesses
        for (int i = 0; i < 8; i++) begin
            do_access(vecs[i].ch, vecs[i].we, vecs[i].addr, vecs[i].wdata, ack_v, rd, lat);
            chk($sformatf("vec%0d_ack", i), 32'(ack_v), 32'(1) << vecs[i].ch);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(WC + 2));
            if (!vecs[i].we) chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rdata));
        end

        // Single read from ch1 with strobe timing
        observe(1, 1'b0, 18'h00123, '0, oe_n, we_n, wd_n, addr_bad, ack_at, acks, ack_v, rd);
        chk("rd_oe_width", 32'(oe_n), 32'(WC + 1));
        chk("rd_we_idle", 32'(we_n), 32'd0);
        chk("rd_addr", 32'(addr_bad), 32'd0);
        chk("rd_ack_at", 32'(ack_at), 32'(WC + 2));
        chk("rd_ack_ch", 32'(ack_v), 32'h2);
        chk("rd_data", 32'(rd), 32'hBEEF);

        // Write then read-back on ch0
        observe(0, 1'b1, 18'd5, 16'h1234, oe_n, we_n, wd_n, addr_bad, ack_at, acks, ack_v, rd);
        acks_total = acks;
        chk("wr_we_width", 32'(we_n), 32'(WC + 1));
        chk("wr_data_on_pins", 32'(wd_n), 32'(WC + 1));
        chk("wr_oe_idle", 32'(oe_n), 32'd0);
        chk("wr_addr", 32'(addr_bad), 32'd0);
        chk("wr_ack_ch", 32'(ack_v), 32'h1);
        chk("wr_rdata_kept", 32'(rdata), 32'hBEEF);
        observe(0, 1'b0, 18'd5, '0, oe_n, we_n, wd_n, addr_bad, ack_at, acks, ack_v, rd);
        acks_total += acks;
        chk("rb_data", 32'(rd), 32'h1234);
        chk("rb_ack_count", 32'(acks_total), 32'd2);

        // All channels requesting continuously
        pulse_reset();
        t0 = int'($time);
        for (int c = 0; c < NCH; c++) set_ch(c, 1'b1, 1'b0, AW'(c), '0);
        n_got = 0;
`ifdef SRAM_ARB_PRIORITY0_EN
        collect(4);
        ch_req[0] = 1'b0;
        collect(8);
        exp_ord = '{0, 0, 0, 0, 1, 2, 3, 1};
        n_exp = 8;
`else
        collect(6);
        exp_ord = '{0, 1, 2, 3, 0, 1, 0, 0};
        n_exp = 6;
`endif
        ch_req = '0;
        chk("rr_count", 32'(n_got), 32'(n_exp));
        for (int i = 0; i < n_got && i < n_exp; i++) begin
            chk($sformatf("rr_order%0d", i), 32'(ord[i]), 32'(exp_ord[i]));
            if (i == 0) chk("rr_first_time", 32'(tim[0] - t0), 32'(10 * (WC + 2)));
            else chk($sformatf("rr_gap%0d", i), 32'(tim[i] - tim[i-1]), 32'(10 * (WC + 3)));
        end
        repeat (3) @(negedge clk);

        // Reset asserted in the middle of a write
        set_ch(2, 1'b1, 1'b1, 18'h003F0, 16'h5555);
        @(negedge clk);
        chk("abort_we_low", 32'(WE), 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("abort_strobes", {29'd0, CS, OE, WE}, 32'h7);
        chk("abort_out_en", 32'(data_pins_out_en), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        ch_req = '0;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ch_ack != '0) acks++;
        end
        chk("abort_no_ack", 32'(acks), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        do_access(1, 1'b1, 18'd9, 16'h7777, ack_v, rd, lat);
        chk("post_abort_wr_ack", 32'(ack_v), 32'h2);
        chk("post_abort_wr_lat", 32'(lat), 32'(WC + 2));
        do_access(1, 1'b0, 18'd9, '0, ack_v, rd, lat);
        chk("post_abort_rd", 32'(rd), 32'h7777);

        // Randomised traffic against a transaction-level model
        pulse_reset();
        begin
            logic          pend [0:NCH-1];
            logic          p_we [0:NCH-1];
            logic [AW-1:0] p_a  [0:NCH-1];
            logic [DW-1:0] p_d  [0:NCH-1];
            int m_last, free_edge, ack_edge, grant_edge, g, c;
            logic m_we;
            logic [DW-1:0] m_rd;
            logic [NCH-1:0] exp_ack;
            m_last = NCH - 1; free_edge = 0; ack_edge = 0; grant_edge = 1; g = 0;
            m_we = 1'b0; m_rd = '0;
            for (int i = 0; i < NCH; i++) begin pend[i] = 1'b0; p_we[i] = 1'b0; p_a[i] = '0; p_d[i] = '0; end
            for (int n = 1; n <= 500; n++) begin
                for (int i = 0; i < NCH; i++) begin
                    if (!pend[i] && $urandom_range(0, 3) == 0) begin
                        pend[i] = 1'b1;
                        p_we[i] = 1'($urandom_range(0, 1));
                        p_a[i]  = AW'($urandom_range(0, 15));
                        p_d[i]  = DW'($urandom);
                        set_ch(i, 1'b1, p_we[i], p_a[i], p_d[i]);
                    end
                end
                // Arbiter free and someone asking: pick per the grant rule
                if (n >= free_edge && ch_req != '0) begin
                    g = -1;
`ifdef SRAM_ARB_PRIORITY0_EN
                    if (ch_req[0]) g = 0;
                    for (int j = 1; j <= NCH && g < 0; j++) begin
                        c = (m_last + j) % NCH;
                        if (c != 0 && ch_req[c]) g = c;
                    end
`else
                    for (int j = 1; j <= NCH && g < 0; j++) begin
                        c = (m_last + j) % NCH;
                        if (ch_req[c]) g = c;
                    end
`endif
                    m_last = g; grant_edge = n;
                    ack_edge = n + WC + 1; free_edge = n + WC + 3;
                    m_we = p_we[g];
                    if (m_we) shadow[p_a[g][9:0]] = p_d[g];
                    else m_rd = shadow[p_a[g][9:0]];
                end
                @(negedge clk);
                exp_ack = '0;
                if (n == ack_edge) exp_ack[g] = 1'b1;
                chk("rand_ack", 32'(ch_ack), 32'(exp_ack));
                chk("rand_busy", 32'(busy), 32'(n >= grant_edge && n <= ack_edge));
                if (n == ack_edge) begin
                    if (!m_we) chk("rand_rdata", 32'(rdata), 32'(m_rd));
                    pend[g] = 1'b0;
                    ch_req[g] = 1'b0;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
